// File: rtl/psw_pkg.sv
// Shared encodings for the program-status-word flag unit: opcodes, function codes,
// FSM states and PSW bit positions.
package psw_pkg;

    localparam logic [4:0] OP_ALU     = 5'b00000;
    localparam logic [4:0] OP_STR_CMP = 5'b00110;
    localparam logic [4:0] OP_ADDI    = 5'b00111;
    localparam logic [4:0] OP_SUBI    = 5'b01000;

    localparam logic [1:0] F_ADD = 2'b00;
    localparam logic [1:0] F_ADC = 2'b01;
    localparam logic [1:0] F_SUB = 2'b10;
    localparam logic [1:0] F_SBB = 2'b11;
    localparam logic [1:0] F_CMP = 2'b01;

    localparam int unsigned PSW_Z = 1;
    localparam int unsigned PSW_C = 0;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_e;

    // Field order matches the PSW bit indices: z at bit 1, c at bit 0.
    typedef struct packed {
        logic z;
        logic c;
    } flags_t;

endpackage

// File: rtl/psw_flag_calc.sv
// Combinational decode of flag-setting instructions and WIDTH+1-bit Z/C computation.
module psw_flag_calc
    import psw_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [4:0]       major_i,
    input  logic [1:0]       fn_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             cin_i,
    output logic             set_flags_o,
    output flags_t           flags_o
);

    localparam int unsigned SW = WIDTH + 1;

    logic          is_sub;
    logic          use_cin;
    logic [SW-1:0] a_ext;
    logic [SW-1:0] b_ext;
    logic [SW-1:0] c_ext;
    logic [SW-1:0] sum;

    always_comb begin
        set_flags_o = 1'b0;
        is_sub      = 1'b0;
        use_cin     = 1'b0;
        case (major_i)
            OP_ALU: begin
                set_flags_o = 1'b1;
                case (fn_i)
                    F_ADD:   ;
                    F_ADC:   use_cin = 1'b1;
                    F_SUB:   is_sub  = 1'b1;
                    F_SBB: begin
                        is_sub  = 1'b1;
                        use_cin = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_STR_CMP: begin
                if (fn_i == F_CMP) begin
                    set_flags_o = 1'b1;
                    is_sub      = 1'b1;
                end
            end
            OP_ADDI: set_flags_o = 1'b1;
            OP_SUBI: begin
                set_flags_o = 1'b1;
                is_sub      = 1'b1;
            end
            default: ;
        endcase
    end

    // For subtract forms the top bit wraps to the unsigned borrow.
    always_comb begin
        a_ext = {1'b0, op_a_i};
        b_ext = {1'b0, op_b_i};
        c_ext = SW'(use_cin & cin_i);
        sum   = is_sub ? (a_ext - b_ext - c_ext) : (a_ext + b_ext + c_ext);
        flags_o.c = sum[WIDTH];
        flags_o.z = (sum[WIDTH-1:0] == '0);
    end

endmodule

// File: rtl/psw_flag_unit.sv
// PSW writer: captures Z/C for flag-setting instructions at execute, holds them pending,
// and commits them to PSW_NZC on write-back; also supplies carry-in for ADC/SBB.
module psw_flag_unit
    import psw_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic [15:0]      InsE,
    input  logic             ExEn,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    input  logic             WbEn,
    input  logic             Flush,
    output logic [1:0]       PSW_NZC,
    output logic             CarryIn,
    output logic             FlagPending,
    output logic             Overrun
);

    state_e state_q, state_d;
    flags_t pend_q,  pend_d;
    flags_t psw_q,   psw_d;
    logic   ovr_q,   ovr_d;
    logic   carry_q, carry_d;

    logic   set_flags;
    flags_t new_flags;
    logic   capture;
    logic   unused_ins;

    assign unused_ins = ^InsE[10:2];

    psw_flag_calc #(.WIDTH(WIDTH)) u_calc (
        .major_i     (InsE[15:11]),
        .fn_i        (InsE[1:0]),
        .op_a_i      (OpA),
        .op_b_i      (OpB),
        .cin_i       (carry_q),
        .set_flags_o (set_flags),
        .flags_o     (new_flags)
    );

    assign capture = ExEn & set_flags;

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            psw_q   <= '0;
            ovr_q   <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            psw_q   <= psw_d;
            ovr_q   <= ovr_d;
            carry_q <= carry_d;
        end
    end

    // Flush outranks WbEn; a capture in the same cycle always refills the pending slot.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        psw_d   = psw_q;
        ovr_d   = ovr_q;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    pend_d  = new_flags;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (Flush) begin
                    if (capture) begin
                        pend_d = new_flags;
                    end else begin
                        pend_d  = '0;
                        state_d = IDLE;
                    end
                end else if (WbEn) begin
                    psw_d = pend_q;
                    if (capture) begin
                        pend_d = new_flags;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (capture) begin
                    pend_d = new_flags;
                    ovr_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        carry_d = (state_d == PEND) ? pend_d.c : psw_d.c;
    end

    assign PSW_NZC     = {psw_q[PSW_Z], psw_q[PSW_C]};
    assign CarryIn     = carry_q;
    assign FlagPending = (state_q == PEND);
    assign Overrun     = ovr_q;

endmodule

// File: tb/tb_psw_flag_unit.sv
// Directed scoreboard bench for psw_flag_unit; expected vector is {PSW_NZC, CarryIn, FlagPending, Overrun}.
module tb_psw_flag_unit;

    localparam int unsigned WIDTH = 16;

    localparam logic [15:0] I_ADD  = 16'h0000;
    localparam logic [15:0] I_ADC  = 16'h0001;
    localparam logic [15:0] I_SBB  = 16'h0003;
    localparam logic [15:0] I_SUB  = 16'h0002;
    localparam logic [15:0] I_CMP  = 16'h3001;
    localparam logic [15:0] I_STR  = 16'h3000;
    localparam logic [15:0] I_ADDI = 16'h3800;
    localparam logic [15:0] I_SUBI = 16'h4000;
    localparam logic [15:0] I_LHI  = 16'h0812;
    localparam logic [15:0] I_BEQ  = 16'hC105;
    localparam logic [15:0] I_MOV  = 16'h5803;
    localparam logic [15:0] I_OUTR = 16'hE000;

    logic             clk = 1'b0;
    logic             Rst;
    logic [15:0]      InsE;
    logic             ExEn;
    logic [WIDTH-1:0] OpA;
    logic [WIDTH-1:0] OpB;
    logic             WbEn;
    logic             Flush;
    logic [1:0]       PSW_NZC;
    logic             CarryIn;
    logic             FlagPending;
    logic             Overrun;

    typedef struct {
        string      tag;
        logic [4:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int        checks = 0;
    int        errors = 0;

    psw_flag_unit #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .Rst         (Rst),
        .InsE        (InsE),
        .ExEn        (ExEn),
        .OpA         (OpA),
        .OpB         (OpB),
        .WbEn        (WbEn),
        .Flush       (Flush),
        .PSW_NZC     (PSW_NZC),
        .CarryIn     (CarryIn),
        .FlagPending (FlagPending),
        .Overrun     (Overrun)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [4:0] exp);
        sb_entry_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic check_front();
        sb_entry_t  e;
        logic [4:0] obs;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty observed=none expected=entry");
        end else begin
            e   = sb_q.pop_front();
            obs = {PSW_NZC, CarryIn, FlagPending, Overrun};
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.exp);
            end
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then check after the next rising edge.
    task automatic cyc(input string tag, input logic [15:0] ins, input logic [15:0] a,
                       input logic [15:0] b, input logic ex, input logic wb,
                       input logic fl, input logic [4:0] exp);
        InsE  = ins;
        OpA   = a;
        OpB   = b;
        ExEn  = ex;
        WbEn  = wb;
        Flush = fl;
        push(tag, exp);
        @(negedge clk);
        check_front();
    endtask

    initial begin
        Rst = 1'b1; InsE = '0; ExEn = 1'b0; OpA = '0; OpB = '0; WbEn = 1'b0; Flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        push("reset", 5'b00_0_0_0);
        check_front();
        Rst = 1'b0;

        cyc("add_ex",     I_ADD,  16'hFFFF, 16'h0001, 1, 0, 0, 5'b00_1_1_0);
        cyc("add_wb",     I_ADD,  16'h0000, 16'h0000, 0, 1, 0, 5'b11_1_0_0);
        cyc("adc_ex",     I_ADC,  16'h0000, 16'h0000, 1, 0, 0, 5'b11_0_1_0);
        cyc("adc_wb",     I_ADD,  16'h0000, 16'h0000, 0, 1, 0, 5'b00_0_0_0);
        cyc("cmp_eq_ex",  I_CMP,  16'h0005, 16'h0005, 1, 0, 0, 5'b00_0_1_0);
        cyc("cmp_eq_wb",  I_ADD,  16'h0000, 16'h0000, 0, 1, 0, 5'b10_0_0_0);
        cyc("cmp_lt_ex",  I_CMP,  16'h0003, 16'h0005, 1, 0, 0, 5'b10_1_1_0);
        cyc("cmp_lt_wb",  I_ADD,  16'h0000, 16'h0000, 0, 1, 0, 5'b01_1_0_0);
        cyc("subi_ex",    I_SUBI, 16'h8000, 16'h0001, 1, 0, 0, 5'b01_0_1_0);
        cyc("subi_wb",    I_ADD,  16'h0000, 16'h0000, 0, 1, 0, 5'b00_0_0_0);
        cyc("cmp_b_ex",   I_CMP,  16'h0000, 16'h0001, 1, 0, 0, 5'b00_1_1_0);
        cyc("cmp_b_wb",   I_ADD,  16'h0000, 16'h0000, 0, 1, 0, 5'b01_1_0_0);
        cyc("sbb_ex",     I_SBB,  16'h0005, 16'h0004, 1, 0, 0, 5'b01_0_1_0);
        cyc("sbb_wb",     I_ADD,  16'h0000, 16'h0000, 0, 1, 0, 5'b10_0_0_0);

        cyc("flush_ex",   I_ADD,  16'hFFFF, 16'h0001, 1, 0, 0, 5'b10_1_1_0);
        cyc("flush_wb",   I_ADD,  16'h0000, 16'h0000, 0, 1, 1, 5'b10_0_0_0);

        cyc("nf_lhi",     I_LHI,  16'h0000, 16'h0000, 1, 0, 0, 5'b10_0_0_0);
        cyc("nf_beq",     I_BEQ,  16'hFFFF, 16'h0001, 1, 0, 0, 5'b10_0_0_0);
        cyc("nf_mov",     I_MOV,  16'h0000, 16'h0000, 1, 0, 0, 5'b10_0_0_0);
        cyc("nf_str",     I_STR,  16'h0000, 16'h0000, 1, 0, 0, 5'b10_0_0_0);
        cyc("nf_outr",    I_OUTR, 16'h0003, 16'h0005, 1, 0, 0, 5'b10_0_0_0);
        cyc("idle_wb",    I_ADD,  16'h0000, 16'h0000, 0, 1, 0, 5'b10_0_0_0);
        cyc("idle_flush", I_ADD,  16'h0000, 16'h0000, 0, 0, 1, 5'b10_0_0_0);

        cyc("exwb_idle",  I_ADDI, 16'h0001, 16'h0001, 1, 1, 0, 5'b10_0_1_0);
        cyc("exwb_wb",    I_ADD,  16'h0000, 16'h0000, 0, 1, 0, 5'b00_0_0_0);

        cyc("bb_ex1",     I_CMP,  16'h0003, 16'h0005, 1, 0, 0, 5'b00_1_1_0);
        cyc("bb_ex2_wb",  I_ADD,  16'hFFFF, 16'h0001, 1, 1, 0, 5'b01_1_1_0);
        cyc("bb_wb",      I_ADD,  16'h0000, 16'h0000, 0, 1, 0, 5'b11_1_0_0);

        cyc("fx_ex1",     I_CMP,  16'h0005, 16'h0005, 1, 0, 0, 5'b11_0_1_0);
        cyc("fx_ex2_fl",  I_SUB,  16'h0003, 16'h0005, 1, 1, 1, 5'b11_1_1_0);
        cyc("fx_wb",      I_ADD,  16'h0000, 16'h0000, 0, 1, 0, 5'b01_1_0_0);

        cyc("ov_ex1",     I_CMP,  16'h0005, 16'h0005, 1, 0, 0, 5'b01_0_1_0);
        cyc("ov_ex2",     I_ADD,  16'hFFFF, 16'h0001, 1, 0, 0, 5'b01_1_1_1);
        cyc("ov_hold",    I_ADD,  16'h0000, 16'h0000, 0, 0, 0, 5'b01_1_1_1);
        cyc("ov_wb",      I_ADD,  16'h0000, 16'h0000, 0, 1, 0, 5'b11_1_0_1);

        cyc("rst_pend",   I_CMP,  16'h0005, 16'h0005, 1, 0, 0, 5'b11_0_1_1);
        ExEn = 1'b0;
        Rst  = 1'b1;
        push("rst_async", 5'b00_0_0_0);
        #1;
        check_front();
        @(negedge clk);
        push("rst_held", 5'b00_0_0_0);
        check_front();
        Rst = 1'b0;
        cyc("rst_wb",     I_ADD,  16'h0000, 16'h0000, 0, 1, 0, 5'b00_0_0_0);

        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/psw_flag_unit.md
# psw_flag_unit

Program-status-word writer for the multicycle RISC core. It decodes the instruction in the execute stage and computes the Z (zero) and C (carry/borrow) flags from the ALU operands for flag-setting instructions. It holds the result as pending until the write-back commit strobe, then drives `PSW_NZC`, the register that the branch-decision logic reads for BCC/BCS/BEQ/BNE. It also supplies the carry-in that the ALU needs for ADC/SBB.

## Interface
- `WIDTH`, 16, datapath/operand width in bits.

- `clk`  in  1  system clock, rising edge.
- `Rst`  in  1  asynchronous, active-high reset.
- `InsE`  in  16  instruction word in the execute stage.
- `ExEn`  in  1  execute strobe; one-cycle pulse per instruction.
- `OpA`  in  WIDTH  ALU operand A.
- `OpB`  in  WIDTH  ALU operand B. For ADDI/SUBI this is the already-extended immediate.
- `WbEn`  in  1  write-back commit strobe; one-cycle pulse.
- `Flush`  in  1  discards the pending flags.
- `PSW_NZC`  out  2  committed flags: bit1 = Z, bit0 = C.
- `CarryIn`  out  1  effective carry for ADC/SBB.
- `FlagPending`  out  1  pending flags are awaiting commit.
- `Overrun`  out  1  sticky protocol-violation indicator.

## Operation
- **Flag-setting decode** (`InsE[15:11]` major opcode, `InsE[1:0]` function):
  - 00000/00 ADD, 00000/01 ADC, 00000/10 SUB, 00000/11 SBB.
  - 00110/01 CMP.
  - 00111 ADDI, 01000 SUBI.
  - All other encodings set no flags, including 00110/00 STRrr, MOV, loads, branches, jumps, OutR and HLT.
- **Arithmetic** is done in WIDTH+1 bits; `s` is the WIDTH+1-bit result.
  - ADD/ADDI: `s = A + B`.
  - ADC: `s = A + B + cin`.
  - SUB/SUBI/CMP: `s = A - B`.
  - SBB: `s = A - B - cin`.
  - C = `s[WIDTH]`. For subtract forms this is the borrow: 1 iff A < B (+cin) unsigned.
  - Z = (`s[WIDTH-1:0]` == 0).
- `cin` is the current `CarryIn`.
- `CarryIn` = pending C while `FlagPending`, otherwise `PSW_NZC[0]`. It is driven from registers only and has no combinational path from inputs.
- **FSM states:** IDLE, PEND.
  - IDLE, `ExEn` with a flag-setting instruction: capture the pending flags, go to PEND.
  - IDLE, any other input (including `WbEn` or `Flush`): stay in IDLE, no change.
  - PEND, `Flush`: discard the pending flags, go to IDLE. `Flush` beats a simultaneous `WbEn`.
  - PEND, `WbEn` without `Flush`: `PSW_NZC` ← pending flags, go to IDLE.
  - PEND, `WbEn` together with a flag-setting `ExEn`: commit the old flags and capture the new ones; stay in PEND.
  - PEND, flag-setting `ExEn` without `WbEn`: the new flags overwrite the pending ones, `Overrun` ← 1, stay in PEND.
  - PEND, `Flush` together with a flag-setting `ExEn`: discard the old flags, capture the new ones, stay in PEND.
- `Overrun` is cleared only by `Rst`.
- `FlagPending` = (state == PEND).

## Timing
- Reset values: `PSW_NZC` = 2'b00, `CarryIn` = 0, `FlagPending` = 0, `Overrun` = 0, state IDLE, pending register cleared.
- Reset is asynchronous and takes effect mid-operation: pending flags are lost and nothing is committed.
- Capture: pending flags are valid in the cycle after the `ExEn` edge.
- Commit: `PSW_NZC` changes in the cycle after the `WbEn` edge. Minimum `ExEn`→`PSW_NZC` latency is 2 cycles (`WbEn` one cycle after `ExEn`).
- `ExEn` and `WbEn` in the same cycle from IDLE: the capture happens and the `WbEn` is ignored.
- All outputs are registered or register-derived.

## Structure
- Package `psw_pkg`:
  - major-opcode constants `OP_ALU`=5'b00000, `OP_STR_CMP`=5'b00110, `OP_ADDI`=5'b00111, `OP_SUBI`=5'b01000;
  - function codes `F_ADD`/`F_ADC`/`F_SUB`/`F_SBB`, and `F_CMP`=2'b01;
  - state encoding IDLE/PEND;
  - bit indices `PSW_Z`=1, `PSW_C`=0.
- Sub-module `psw_flag_calc`: combinational decode plus WIDTH+1-bit arithmetic, producing `{set_flags, z, c}`.
- Top level: FSM, pending and committed registers, `CarryIn` mux, `Overrun`.

## Test plan
- **Add carry:** ADD with `OpA`=0xFFFF, `OpB`=0x0001, `WbEn` one cycle later → `PSW_NZC`=2'b11 one cycle after `WbEn`. Then ADC with 0x0000 + 0x0000 → result 0x0001, `PSW_NZC`=2'b00.
- **Compare:** CMP 0x0005 vs 0x0005 → 2'b10. CMP 0x0003 vs 0x0005 → 2'b01. SUBI 0x8000 − 0x0001 → 2'b00.
- **Subtract with borrow:** set C=1 via CMP 0x0000 vs 0x0001, commit, then SBB 0x0005 − 0x0004 → result 0, `PSW_NZC`=2'b10. `CarryIn`=1 while that CMP is still pending.
- **Flush:** `Flush` and `WbEn` together in PEND → `PSW_NZC` unchanged, `FlagPending`=0.
- **Non-flag instructions:** 0x08xx (LHI), 0xC1xx (BEQ), 0x58xx (MOV), 0x30xx with `[1:0]`=00 (STRrr), 0xE0xx (OutR) → `FlagPending` stays 0 and `PSW_NZC` is unchanged.
- **Overrun and reset:** two flag-setting `ExEn` pulses without `WbEn` → `Overrun`=1 and a later `WbEn` commits the second result. Assert `Rst` while PEND → all outputs 0 immediately.
